// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-memory initiator.
//   - state_e        : controller states (IDLE, BUSY, DONE)
//   - DEF_*          : default geometry and timeout values
//   - addr_in_range  : word-aligned byte-address window check
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_DEPTH_WORDS = 64;
    localparam int unsigned DEF_TIMEOUT     = 15;

    // True when addr is word aligned and falls inside the window
    // [base, base + 4*depthWords). The sums are widened to 34 bits so a
    // window sitting near the top of the 32-bit space cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depthWords);
        logic [33:0] limit;
        limit = {2'b00, base} + {depthWords, 2'b00};
        return ({2'b00, addr} >= {2'b00, base}) &&
               ({2'b00, addr} <  limit) &&
               (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
// Counts cycles spent waiting for the memory responder and flags when the
// wait budget is used up.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   clear_i   in   return the count to zero (has priority over enable_i)
//   enable_i  in   one more cycle without an acknowledge
//   expire_o  out  this enabled cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module mem_timeout_cnt
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [3:0] count_q;

    // The count holds how many waiting cycles have already elapsed, so the
    // TIMEOUT-th waiting cycle is the one that sees TIMEOUT-1 here. Expiry is
    // flagged during that cycle so the controller can leave BUSY on its edge.
    assign expire_o = enable_i && (count_q == 4'(TIMEOUT - 1));

    // Clear wins over enable so the count restarts cleanly for every access,
    // even if the controller leaves BUSY on the same edge it would advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (clear_i) begin
            count_q <= 4'd0;
        end else if (enable_i) begin
            count_q <= count_q + 4'd1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Multi-cycle initiator for the MEM stage. Takes the pipeline's load/store
// request, converts the byte address into a word index, runs a req/ack
// handshake with the data-memory responder and freezes the pipeline until
// the access finishes. Load data is registered on data_mem for write-back.
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   MEM_R_EN, MEM_W_EN   load / store request (store wins if both high)
//   alu_res              byte address
//   rm_val               store data
//   freeze               pipeline hold (combinational)
//   data_mem             registered load result
//   addr_err             one-cycle pulse in DONE: bad address or timeout
//   mem_req, mem_we      request and direction toward the responder
//   mem_addr, mem_wdata  word index and write data, stable while mem_req
//   mem_ack, mem_rdata   responder completion and read data
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_R_EN,
    input  logic          MEM_W_EN,
    input  logic [31:0]   alu_res,
    input  logic [31:0]   rm_val,
    output logic          freeze,
    output logic [31:0]   data_mem,
    output logic          addr_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q;
    logic          memReq_q;
    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [31:0]   memWdata_q;
    logic [31:0]   dataMem_q;
    logic          err_q;

    logic          accessReq;
    logic          addrOk;
    logic [AW-1:0] wordIdx;
    logic          cntClear;
    logic          cntEnable;
    logic          cntExpire;

    // Request decode and address translation. The word index is taken even
    // for out-of-range addresses; it is simply never presented with mem_req.
    assign accessReq = MEM_R_EN || MEM_W_EN;
    assign addrOk    = addr_in_range(alu_res, 32'(BASE_ADDR), 32'(DEPTH_WORDS));
    assign wordIdx   = AW'((alu_res - 32'(BASE_ADDR)) >> 2);

    // The pipeline must stall in the very cycle the request appears, before
    // the FSM has had an edge to react, hence the IDLE term is combinational.
    assign freeze = ((state_q == IDLE) && accessReq) || (state_q == BUSY);

    // The wait counter only runs while a request is outstanding and the
    // responder has not answered; any other state keeps it at zero.
    assign cntClear  = (state_q != BUSY);
    assign cntEnable = (state_q == BUSY) && !mem_ack;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .expire_o (cntExpire)
    );

    // Main controller. IDLE latches the access and either launches it or,
    // for a bad address, skips straight to DONE with the error set. BUSY
    // keeps the request fields frozen until ack or expiry. DONE releases the
    // pipeline for one cycle and never looks at the enables, so a held
    // request is not accepted twice. err_q is only ever set on entry to DONE
    // and cleared on leaving it, which makes addr_err a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            dataMem_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (accessReq) begin
                        memWe_q    <= MEM_W_EN;
                        memAddr_q  <= wordIdx;
                        memWdata_q <= rm_val;
                        if (addrOk) begin
                            state_q  <= BUSY;
                            memReq_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            if (!MEM_W_EN) begin
                                dataMem_q <= '0;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_q  <= DONE;
                        memReq_q <= 1'b0;
                        if (!memWe_q) begin
                            dataMem_q <= mem_rdata;
                        end
                    end else if (cntExpire) begin
                        state_q  <= DONE;
                        memReq_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (!memWe_q) begin
                            dataMem_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign data_mem  = dataMem_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A behavioural responder memory
// answers the DUT's handshake, while an independent reference model works
// out, from the byte address and ack delay alone, how long the pipeline
// should stall, whether an error pulse is due and what data_mem must hold.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int BASE  = 1024;
    localparam int DEPTH = 64;
    localparam int TMO   = 15;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] alu_res;
    logic [31:0] rm_val;
    logic        freeze;
    logic [31:0] data_mem;
    logic        addr_err;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    // Responder storage (driven by what the DUT asks for) and the reference
    // model's own view of memory (driven by what the pipeline asked for).
    logic [31:0] respMem [DEPTH];
    logic [31:0] refMem  [DEPTH];
    logic [31:0] modelData;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .alu_res   (alu_res),
        .rm_val    (rm_val),
        .freeze    (freeze),
        .data_mem  (data_mem),
        .addr_err  (addr_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Free-running 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one pipeline access from its IDLE cycle to its DONE cycle.
    // ackDelay = k acks in the k-th BUSY cycle; 0 or > TMO never acks.
    // The task returns while the DUT sits in DONE so that the next call
    // presents its request in the very next cycle (back-to-back).
    task automatic applyStimulus(input logic rEn, input logic wEn,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input int ackDelay, input string tag);
        logic       ok;
        logic       timedOut;
        logic       isStore;
        logic       reqBad;
        logic [5:0] expIdx;
        int         expFreeze;
        int         fz;
        int         busyN;
        int         cyc;

        isStore  = wEn;
        ok       = (addr >= 32'(BASE)) && (addr < 32'(BASE + 4 * DEPTH)) &&
                   ((addr % 4) == 0);
        expIdx   = ok ? 6'((addr - 32'(BASE)) / 4) : 6'd0;
        timedOut = ok && (ackDelay < 1 || ackDelay > TMO);
        if (!ok)
            expFreeze = 1;
        else if (timedOut)
            expFreeze = TMO + 1;
        else
            expFreeze = ackDelay + 1;

        @(negedge clk);
        MEM_R_EN = rEn;
        MEM_W_EN = wEn;
        alu_res  = addr;
        rm_val   = wdata;
        mem_ack  = 1'b0;
        #1;
        checkOutput({tag, "/errBeforeStart"}, 32'(addr_err), 32'd0);

        fz     = 0;
        busyN  = 0;
        cyc    = 0;
        reqBad = 1'b0;
        while (freeze === 1'b1 && cyc < 40) begin
            fz++;
            if (mem_req === 1'b1) begin
                busyN++;
                if (mem_we !== isStore || mem_addr !== expIdx ||
                    (isStore && mem_wdata !== wdata))
                    reqBad = 1'b1;
                if (busyN == ackDelay) begin
                    mem_ack = 1'b1;
                    if (mem_we === 1'b1)
                        respMem[mem_addr] = mem_wdata;
                    mem_rdata = respMem[mem_addr];
                end
            end else if (mem_req !== 1'b0) begin
                reqBad = 1'b1;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            #1;
            cyc++;
        end

        // Reference outcome of this access
        if (!isStore) begin
            if (!ok || timedOut)
                modelData = 32'd0;
            else
                modelData = refMem[expIdx];
        end else if (ok && !timedOut) begin
            refMem[expIdx] = wdata;
        end

        checkOutput({tag, "/freezeCycles"}, 32'(fz), 32'(expFreeze));
        checkOutput({tag, "/busyCycles"}, 32'(busyN), ok ? 32'(expFreeze - 1) : 32'd0);
        checkOutput({tag, "/reqFields"}, 32'(reqBad), 32'd0);
        checkOutput({tag, "/reqInDone"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "/addrErr"}, 32'(addr_err), 32'(!ok || timedOut));
        checkOutput({tag, "/dataMem"}, data_mem, modelData);
    endtask

    initial begin
        logic [31:0] a;
        logic        r;
        logic        w;
        int          sel;
        int          d;

        checks    = 0;
        errors    = 0;
        modelData = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            respMem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            refMem[i]  = respMem[i];
        end
        rst       = 1'b1;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        alu_res   = 32'd0;
        rm_val    = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset/freeze", 32'(freeze), 32'd0);
        checkOutput("reset/memReq", 32'(mem_req), 32'd0);
        checkOutput("reset/memWe", 32'(mem_we), 32'd0);
        checkOutput("reset/memAddr", 32'(mem_addr), 32'd0);
        checkOutput("reset/memWdata", mem_wdata, 32'd0);
        checkOutput("reset/dataMem", data_mem, 32'd0);
        checkOutput("reset/addrErr", 32'(addr_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Store then load at the first word, ack in the first BUSY cycle
        $display("[TB] store/load at base");
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 1, "storeBase");
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1, "loadBase");
        checkOutput("loadBase/value", data_mem, 32'h1234_5678);

        // Last word with a 3-cycle ack delay
        $display("[TB] last word, delayed ack");
        applyStimulus(1'b0, 1'b1, 32'd1276, 32'hCAFE_F00D, 3, "storeLast");
        applyStimulus(1'b1, 1'b0, 32'd1276, 32'h0, 3, "loadLast");
        checkOutput("loadLast/value", data_mem, 32'hCAFE_F00D);

        // Bad addresses: below window, past window, misaligned
        $display("[TB] bad addresses");
        applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0, 1, "bad1020");
        applyStimulus(1'b1, 1'b0, 32'd1280, 32'h0, 1, "bad1280");
        applyStimulus(1'b1, 1'b0, 32'd1025, 32'h0, 1, "bad1025");

        // Timeout, then a normal access
        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, 32'd1100, 32'h0, 0, "timeoutLoad");
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 2, "afterTimeout");

        // Both enables high: the store wins and data_mem is untouched
        $display("[TB] both enables");
        applyStimulus(1'b1, 1'b1, 32'd1028, 32'h0BAD_BEEF, 1, "bothStore");
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1, "bothReadBack");
        checkOutput("bothReadBack/value", data_mem, 32'h0BAD_BEEF);

        // Asynchronous reset in the middle of BUSY
        $display("[TB] reset mid-access");
        @(negedge clk);
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        alu_res  = 32'd1040;
        @(negedge clk);
        #1;
        checkOutput("rstMid/reqBefore", 32'(mem_req), 32'd1);
        #2;
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        #1;
        checkOutput("rstMid/reqAsync", 32'(mem_req), 32'd0);
        checkOutput("rstMid/freezeAsync", 32'(freeze), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        modelData = 32'd0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstMid/ackIgnoredReq", 32'(mem_req), 32'd0);
        checkOutput("rstMid/ackIgnoredFreeze", 32'(freeze), 32'd0);
        checkOutput("rstMid/ackIgnoredErr", 32'(addr_err), 32'd0);
        checkOutput("rstMid/ackIgnoredData", data_mem, 32'd0);
        mem_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 1, "afterReset");

        // Randomized back-to-back traffic against the reference model
        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = 32'd1020;
                1:       a = 32'd1280 + 32'(4 * $urandom_range(0, 10));
                2:       a = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                3:       a = $urandom;
                default: a = 32'd1024 + 32'(4 * $urandom_range(0, 63));
            endcase
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(r, w, a, $urandom, d, "random");
        end

        @(negedge clk);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("final/idleFreeze", 32'(freeze), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle initiator for the MEM stage of the ARM32 pipeline. It accepts the pipeline's load/store request (MEM_R_EN, MEM_W_EN, alu_res, rm_val) and translates the byte address into a word index. It drives a request/acknowledge port toward the data-memory responder and freezes the pipeline until the access completes. Read data is registered and presented on data_mem for write-back.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address of word 0.
- DEPTH_WORDS, 64: number of 32-bit words; index width AW = $clog2(DEPTH_WORDS).
- TIMEOUT, 15: maximum cycles to wait for mem_ack, 4-bit counter range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request from pipeline.
- MEM_W_EN  in  1  store request from pipeline.
- alu_res  in  32  byte address.
- rm_val  in  32  store data.
- freeze  out  1  pipeline hold.
- data_mem  out  32  registered load result.
- addr_err  out  1  one-cycle pulse: bad address or timeout.
- mem_req  out  1  request to responder.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  AW  word index.
- mem_wdata  out  32  write data.
- mem_ack  in  1  responder completion.
- mem_rdata  in  32  read data; valid with mem_ack.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE, with MEM_R_EN|MEM_W_EN high:
  - Latch the address, data and op.
  - If both enables are high, write wins.
  - Range check: alu_res ≥ BASE_ADDR, alu_res < BASE_ADDR+4*DEPTH_WORDS, alu_res[1:0]==0.
  - Address in range: go to BUSY.
  - Address out of range: go to DONE without issuing mem_req, with an error flagged.
- mem_addr = (alu_res−BASE_ADDR)>>2, truncated to AW bits and registered.
- BUSY:
  - mem_req=1, and mem_we, mem_addr, mem_wdata are held stable.
  - On mem_ack=1: go to DONE. For a read, capture mem_rdata into data_mem.
  - The timeout counter increments every BUSY cycle without an ack. When it reaches TIMEOUT, go to DONE with an error.
- DONE:
  - freeze=0 and addr_err=1 if the error was flagged.
  - Always return to IDLE; the request is not re-sampled in DONE.
- Load with error: data_mem←0. Stores never change data_mem.
- freeze is combinational: (IDLE & (MEM_R_EN|MEM_W_EN)) | BUSY.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: state IDLE, freeze 0 (no request pending), mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, data_mem 0, addr_err 0, counter 0.
- Reset is asynchronous. Asserted mid-access, mem_req drops immediately and the in-flight access is abandoned.
- Best case, ack in the first BUSY cycle:
  - Cycle 0: IDLE detects the request, freeze=1.
  - Cycle 1: BUSY, req and ack.
  - Cycle 2: DONE, freeze=0, data_mem valid. The pipeline advances at the end of cycle 2.
  - Total freeze is 2 cycles.
- Ack after k BUSY cycles: freeze lasts k+1 cycles.
- Timeout: DONE is entered after TIMEOUT BUSY cycles, and addr_err pulses in that DONE cycle.
- Bad address: cycle 0 IDLE (freeze=1), cycle 1 DONE (addr_err=1). mem_req never rises.
- data_mem holds its value until the next load completes.
- A new request in the cycle after DONE is accepted normally from IDLE, so back-to-back accesses are supported.

## Structure
- Shared package mem_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - BASE_ADDR and DEPTH_WORDS defaults.
  - The address-range check expressed as a function.
- One sub-module, mem_timeout_cnt:
  - Clear, enable and expire signals.
  - 4-bit counter with asynchronous reset.
- FSM, request registers and data_mem register live in mem_access_ctrl.

## Test plan
- Store then load:
  - Store: rm_val=0x12345678 at alu_res=1024, ack on first BUSY cycle. Requires mem_we=1, mem_addr=0, freeze high exactly 2 cycles.
  - Load from 1024: data_mem=0x12345678 in DONE.
- Last word and delayed ack: alu_res=1276 → mem_addr=63. With ack delayed 3 cycles, freeze stays high 4 cycles, and mem_req is held stable throughout.
- Bad addresses: each of alu_res=1020, 1280 and 1025 gives no mem_req, an addr_err pulse in cycle 1, data_mem=0 for a load, and freeze high 1 cycle.
- Timeout: responder never acks → addr_err after 15 BUSY cycles, state returns to IDLE, and the next request proceeds normally.
- Both enables high: MEM_R_EN=MEM_W_EN=1 → write issued (mem_we=1), and data_mem is unchanged.
- Reset mid-BUSY: assert rst → mem_req and freeze go to 0 asynchronously, state is IDLE, and an ack after release is ignored.
